mipsfpga_ahb_micros_timer: RTL and testbench
============================================

// Module: mipsfpga_ahb_micros_timer
// PURPOSE
//  AHB-Lite slave that sits directly downstream of the microseconds counter and consumes its 32-bit count.
//  Exposes the live count to the CPU and runs a programmable compare timer clocked by microsecond ticks.
//  Raises a level interrupt on match and supports one-shot and periodic (auto-reload) modes.
// PARAMETERS
//  ADDR_W         8              offset bits decoded from HADDR[ADDR_W-1:0]; upper bits ignored (HSEL qualifies)
//  RESET_COMPARE  32'hFFFF_FFFF  reset value of the COMPARE register
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  resetn     in   1   reset, synchronous, active-high (asserted = 1 clears the block at the next clk edge)
//  HSEL       in   1   slave select
//  HADDR      in   32  byte address, address phase
//  HTRANS     in   2   transfer type; HTRANS[1]=1 (NONSEQ/SEQ) marks a valid transfer
//  HWRITE     in   1   1=write, address phase
//  HREADY     in   1   bus ready; qualifies the address phase
//  HWDATA     in   32  write data, data phase
//  HRDATA     out  32  read data, data phase
//  HREADYOUT  out  1   tied 1 (zero wait states)
//  HRESP      out  1   tied 0 (OKAY)
//  micros_in  in   32  count from microseconds counter; increments by 1, wraps at 2^32
//  irq        out  1   interrupt = STATUS.MATCH & CTRL.IE
// BEHAVIOUR
//  Register map (word offsets); unmapped reads return 0, unmapped writes ignored:
//   0x00 MICROS   RO  live micros_in
//   0x04 CTRL     RW  [0]EN [1]IE [2]AUTO (periodic); [31:3] read 0
//   0x08 COMPARE  RW  match value
//   0x0C COUNT    RW  timer count; a write loads it
//   0x10 STATUS   W1C [0]MATCH [1]OVERRUN; [31:2] read 0
//  Reset values: CTRL=0, COMPARE=RESET_COMPARE, COUNT=0, STATUS=0, micros_q=0, irq=0.
//  Reset values: data-phase address/valid/write flags = 0, so HRDATA=0 while reset is asserted and on the first cycle after.
//  Reset asserted mid-operation aborts any pending data-phase write. All registers return to reset values at that edge.
//  AHB: capture the address phase when HSEL & HTRANS[1] & HREADY. Register offset, HWRITE and valid into data-phase flops.
//  AHB writes: commit HWDATA at the end of the data phase (next edge).
//  AHB reads: HRDATA is combinational from the data-phase offset. It returns pre-edge register values, never same-edge updates.
//  AHB back-to-back transfers: supported every cycle; a read following a write to the same register returns the new value.
//  Tick: micros_q <= micros_in every cycle; tick = (micros_in != micros_q). Rate is therefore at most one tick per clk.
//  Tick after reset: the first cycle sees a tick iff micros_in != 0.
//  Timer, on tick & EN: nxt = COUNT+1 (mod 2^32).
//   If nxt == COMPARE: set MATCH; if MATCH was already 1, set OVERRUN.
//   If nxt == COMPARE: COUNT <= AUTO ? 0 : nxt. One-shot keeps counting past COMPARE and wraps naturally.
//   Otherwise: COUNT <= nxt.
//  EN=0: COUNT holds, no matches; ticks are still tracked so re-enable does not see a stale tick.
//  Simultaneous events:
//   - CPU write to COUNT and tick on the same edge: the write wins (COUNT=HWDATA, no match evaluated that edge).
//   - W1C to MATCH and match on the same edge: MATCH ends 1, OVERRUN not set (set has priority over clear).
//   - Write to COMPARE and tick on the same edge: match is evaluated against the old COMPARE.
//  COMPARE=0 with AUTO: match on wrap from 0xFFFF_FFFF to 0.
//  irq: combinational from the MATCH and IE flops. It is asserted the cycle after the match edge and deasserted the cycle after the clearing edge.
//  Latency summary: tick on cycle N -> COUNT/STATUS updated at edge ending N -> visible on irq and HRDATA in cycle N+1.
// STRUCTURE
//  Package mipsfpga_timer_pkg: register offset localparams (OFF_MICROS..OFF_STATUS), CTRL/STATUS bit indices, ctrl_t packed struct.
//  Sub-module mipsfpga_timer_core: tick detect, COUNT/COMPARE/STATUS update and priority rules; takes decoded write strobes.
//  Top level: AHB address/data-phase pipeline, register decode, read mux, irq.
// TESTING
//  1 Reset: resetn=1 two cycles with bus traffic.
//    -> HRDATA=0 and irq=0. Reads give CTRL=0, COMPARE=0xFFFF_FFFF, COUNT=0, STATUS=0.
//  2 One-shot: COMPARE=5, CTRL=0x3; step micros_in 100..105.
//    -> MATCH and irq on the 5th tick. COUNT then reads 5 and continues to 6. A 6th match never occurs before wrap.
//  3 Periodic: COMPARE=3, CTRL=0x7; 9 ticks.
//    -> COUNT sequence 1,2,0,1,2,0,1,2,0. OVERRUN=1 after the 2nd match without a clear.
//  4 W1C on the same edge as a match: write STATUS=0x1 timed with the tick.
//    -> MATCH=1, OVERRUN=0. A later plain W1C clears MATCH and irq drops the following cycle.
//  5 Write COUNT=0x10 on the same edge as a tick (EN=1).
//    -> COUNT reads 0x10. Wrap case: COUNT=0xFFFF_FFFF with COMPARE=0, AUTO=1, one tick -> MATCH=1, COUNT=0.
//  6 Back-to-back AHB: write COMPARE=0xAA, then read COMPARE, then idle, then read offset 0x40.
//    -> 0xAA read with no wait states, then 0 for the unmapped offset. Reset asserted mid data-phase write -> write discarded.

Source files
------------

// File: rtl/mipsfpga_timer_pkg.sv
// mipsfpga_timer_pkg: register offsets, bit indices and CTRL layout for the micros timer
package mipsfpga_timer_pkg;
  localparam logic [7:0] OFF_MICROS  = 8'h00;
  localparam logic [7:0] OFF_CTRL    = 8'h04;
  localparam logic [7:0] OFF_COMPARE = 8'h08;
  localparam logic [7:0] OFF_COUNT   = 8'h0C;
  localparam logic [7:0] OFF_STATUS  = 8'h10;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IE     = 1;
  localparam int CTRL_AUTO   = 2;
  localparam int ST_MATCH    = 0;
  localparam int ST_OVERRUN  = 1;
  typedef struct packed {
    logic periodic;
    logic ie;
    logic en;
  } ctrl_t;
endpackage

// File: rtl/mipsfpga_timer_core.sv
// mipsfpga_timer_core: tick detect plus COUNT/COMPARE/STATUS update with write/match priority
module mipsfpga_timer_core
  import mipsfpga_timer_pkg::*;
#(
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_micros,
  input  logic        i_wr_ctrl,
  input  logic        i_wr_compare,
  input  logic        i_wr_count,
  input  logic        i_wr_status,
  input  logic [31:0] i_wdata,
  output ctrl_t       o_ctrl,
  output logic [31:0] o_compare,
  output logic [31:0] o_count,
  output logic [1:0]  o_status
);
  logic [31:0] r_micros_q, r_compare, r_count;
  logic [1:0]  r_status;
  ctrl_t       r_ctrl;
  logic [31:0] w_nxt;
  logic        w_step, w_hit, w_clr_m, w_clr_o;
  // a CPU write to COUNT suppresses both the increment and the match for that edge
  assign w_step  = (i_micros != r_micros_q) & r_ctrl.en & ~i_wr_count;
  assign w_nxt   = r_count + 32'd1;
  assign w_hit   = w_step & (w_nxt == r_compare);
  assign w_clr_m = i_wr_status & i_wdata[ST_MATCH];
  assign w_clr_o = i_wr_status & i_wdata[ST_OVERRUN];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_micros_q <= '0;
      r_ctrl     <= '0;
      r_compare  <= RESET_COMPARE;
      r_count    <= '0;
      r_status   <= '0;
    end else begin
      r_micros_q <= i_micros;
      if (i_wr_ctrl) r_ctrl <= ctrl_t'(i_wdata[CTRL_AUTO:CTRL_EN]);
      if (i_wr_compare) r_compare <= i_wdata;
      r_count <= i_wr_count ? i_wdata : w_step ? ((w_hit & r_ctrl.periodic) ? '0 : w_nxt) : r_count;
      r_status[ST_MATCH]   <= w_hit | (r_status[ST_MATCH] & ~w_clr_m);
      r_status[ST_OVERRUN] <= (w_hit & r_status[ST_MATCH] & ~w_clr_m) | (r_status[ST_OVERRUN] & ~w_clr_o);
    end
  end
  assign o_ctrl    = r_ctrl;
  assign o_compare = r_compare;
  assign o_count   = r_count;
  assign o_status  = r_status;
endmodule

// File: rtl/mipsfpga_ahb_micros_timer.sv
// mipsfpga_ahb_micros_timer: AHB-Lite slave exposing the micros count and a compare timer with irq
module mipsfpga_ahb_micros_timer
  import mipsfpga_timer_pkg::*;
#(
  parameter int          ADDR_W        = 8,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic [31:0] micros_in,
  output logic        irq
);
  logic [ADDR_W-1:0] r_addr;
  logic              r_valid, r_write;
  logic              w_we, w_rd, w_unused;
  ctrl_t             w_ctrl;
  logic [31:0]       w_compare, w_count;
  logic [1:0]        w_status;
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_write <= 1'b0;
    end else begin
      r_valid <= HSEL & HTRANS[1] & HREADY;
      r_addr  <= HADDR[ADDR_W-1:0];
      r_write <= HWRITE;
    end
  end
  assign w_we = r_valid & r_write;
  assign w_rd = r_valid & ~r_write;
  mipsfpga_timer_core #(.RESET_COMPARE(RESET_COMPARE)) u_core (
    .clk          (clk),
    .rst          (resetn),
    .i_micros     (micros_in),
    .i_wr_ctrl    (w_we & (r_addr == ADDR_W'(OFF_CTRL))),
    .i_wr_compare (w_we & (r_addr == ADDR_W'(OFF_COMPARE))),
    .i_wr_count   (w_we & (r_addr == ADDR_W'(OFF_COUNT))),
    .i_wr_status  (w_we & (r_addr == ADDR_W'(OFF_STATUS))),
    .i_wdata      (HWDATA),
    .o_ctrl       (w_ctrl),
    .o_compare    (w_compare),
    .o_count      (w_count),
    .o_status     (w_status)
  );
  always_comb begin
    HRDATA = '0;
    if (w_rd)
      HRDATA = (r_addr == ADDR_W'(OFF_MICROS))  ? micros_in :
               (r_addr == ADDR_W'(OFF_CTRL))    ? {29'd0, w_ctrl} :
               (r_addr == ADDR_W'(OFF_COMPARE)) ? w_compare :
               (r_addr == ADDR_W'(OFF_COUNT))   ? w_count :
               (r_addr == ADDR_W'(OFF_STATUS))  ? {30'd0, w_status} : 32'd0;
  end
  assign irq       = w_status[ST_MATCH] & w_ctrl.ie;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign w_unused  = ^{HADDR[31:ADDR_W], HTRANS[0]};
endmodule

// File: tb/tb_mipsfpga_ahb_micros_timer.sv
// tb_mipsfpga_ahb_micros_timer: directed scenario tests with hand-computed expectations
module tb_mipsfpga_ahb_micros_timer;
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic        HREADY = 1'b1;
  logic [31:0] HWDATA = '0;
  logic [31:0] HRDATA;
  logic        HREADYOUT, HRESP;
  logic [31:0] micros_in = '0;
  logic        irq;
  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  mipsfpga_ahb_micros_timer dut (
    .clk(clk), .resetn(resetn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .micros_in(micros_in), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HADDR = a;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1);
    step();
    bus_idle();
    HWDATA = d;
    step();
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    addr_phase(a, 1'b0);
    step();
    bus_idle();
    #3 d = HRDATA;
    step();
  endtask

  task automatic tick();
    micros_in = micros_in + 32'd1;
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    addr_phase(32'h04, 1'b0);
    step();
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata0 got %h exp 0", HRDATA); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    step();
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata1 got %h exp 0", HRDATA); end
    resetn = 1'b0;
    bus_idle();
    #3;
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL post_reset_hrdata got %h exp 0", HRDATA); end
    step();
    ahb_read(32'h04, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", rd); end
    ahb_read(32'h08, rd);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_compare got %h exp ffffffff", rd); end
    ahb_read(32'h0C, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_count got %h exp 0", rd); end
    ahb_read(32'h10, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", rd); end
  endtask

  task automatic test_one_shot();
    micros_in = 32'd100;
    step();
    step();
    ahb_write(32'h08, 32'd5);
    ahb_write(32'h04, 32'h3);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (irq !== (i == 5)) begin errors++; $display("FAIL oneshot_irq tick %0d got %b exp %b", i, irq, i == 5); end
    end
    ahb_read(32'h0C, rd);
    checks++; if (rd !== 32'd5) begin errors++; $display("FAIL oneshot_count got %h exp 5", rd); end
    ahb_read(32'h10, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL oneshot_status got %h exp 1", rd); end
    tick();
    ahb_read(32'h0C, rd);
    checks++; if (rd !== 32'd6) begin errors++; $display("FAIL oneshot_count6 got %h exp 6", rd); end
    ahb_read(32'h10, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL oneshot_no_overrun got %h exp 1", rd); end
    ahb_write(32'h04, 32'h0);
    ahb_write(32'h10, 32'h3);
  endtask

  task automatic test_periodic();
    logic [31:0] exp_cnt [9] = '{32'd1, 32'd2, 32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2, 32'd0};
    ahb_write(32'h0C, 32'h0);
    ahb_write(32'h08, 32'd3);
    ahb_write(32'h04, 32'h7);
    for (int i = 0; i < 9; i++) begin
      tick();
      ahb_read(32'h0C, rd);
      checks++; if (rd !== exp_cnt[i]) begin errors++; $display("FAIL periodic_count %0d got %h exp %h", i, rd, exp_cnt[i]); end
      if (i == 2 || i == 5) begin
        ahb_read(32'h10, rd);
        checks++; if (rd !== ((i == 2) ? 32'h1 : 32'h3)) begin errors++; $display("FAIL periodic_status %0d got %h", i, rd); end
      end
    end
  endtask

  task automatic test_w1c_race();
    ahb_write(32'h10, 32'h3);
    tick();
    tick();
    addr_phase(32'h10, 1'b1);
    step();
    bus_idle();
    HWDATA = 32'h1;
    micros_in = micros_in + 32'd1;
    step();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_race_irq got %b exp 1", irq); end
    ahb_read(32'h10, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL w1c_race_status got %h exp 1", rd); end
    addr_phase(32'h10, 1'b1);
    step();
    bus_idle();
    HWDATA = 32'h1;
    #3;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_before got %b exp 1", irq); end
    step();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq_after got %b exp 0", irq); end
    ahb_read(32'h10, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w1c_status got %h exp 0", rd); end
  endtask

  task automatic test_count_write_and_wrap();
    addr_phase(32'h0C, 1'b1);
    step();
    bus_idle();
    HWDATA = 32'h10;
    micros_in = micros_in + 32'd1;
    step();
    ahb_read(32'h0C, rd);
    checks++; if (rd !== 32'h10) begin errors++; $display("FAIL count_write_wins got %h exp 10", rd); end
    ahb_write(32'h08, 32'h0);
    ahb_write(32'h0C, 32'hFFFF_FFFF);
    ahb_write(32'h10, 32'h3);
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL wrap_irq got %b exp 1", irq); end
    ahb_read(32'h10, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL wrap_status got %h exp 1", rd); end
    ahb_read(32'h0C, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wrap_count got %h exp 0", rd); end
    ahb_write(32'h04, 32'h0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ie_off_irq got %b exp 0", irq); end
    tick();
    ahb_read(32'h0C, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL disabled_hold got %h exp 0", rd); end
    ahb_write(32'h10, 32'h3);
  endtask

  task automatic test_back_to_back();
    addr_phase(32'h08, 1'b1);
    step();
    HWDATA = 32'hAA;
    addr_phase(32'h08, 1'b0);
    step();
    bus_idle();
    #3;
    checks++; if (HRDATA !== 32'hAA) begin errors++; $display("FAIL b2b_read got %h exp aa", HRDATA); end
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL b2b_resp got %b%b exp 10", HREADYOUT, HRESP); end
    step();
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL b2b_idle got %h exp 0", HRDATA); end
    ahb_read(32'h40, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", rd); end
    ahb_read(32'h00, rd);
    checks++; if (rd !== micros_in) begin errors++; $display("FAIL micros_read got %h exp %h", rd, micros_in); end
    addr_phase(32'h08, 1'b1);
    step();
    bus_idle();
    HWDATA = 32'h55;
    resetn = 1'b1;
    step();
    resetn = 1'b0;
    step();
    ahb_read(32'h08, rd);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_aborts_write got %h exp ffffffff", rd); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_w1c_race();
    test_count_write_and_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
